// File: rtl/parking_sensor_scheduler.sv
// Round-robin scheduler for N HC-SR04 parking sensors: one trigger at a time,
// echo timing, near/far/fault classification and per-bay debounced occupancy.
module parking_sensor_scheduler #(
  parameter int N_SPOTS      = 4,
  parameter int TRIG_CYCLES  = 1000,
  parameter int WAIT_CYCLES  = 100000,
  parameter int MAX_ECHO     = 60000,
  parameter int GUARD_CYCLES = 6000,
  parameter int CONFIRM      = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_SPOTS-1:0]           echo,
  output logic [N_SPOTS-1:0]           trig,
  output logic [N_SPOTS-1:0]           occupied,
  output logic [$clog2(N_SPOTS+1)-1:0] free_count,
  output logic [N_SPOTS-1:0]           fault,
  output logic                         scan_done
);

  localparam int MAX_TW  = (TRIG_CYCLES > WAIT_CYCLES) ? TRIG_CYCLES : WAIT_CYCLES;
  localparam int MAX_EG  = (MAX_ECHO > GUARD_CYCLES) ? MAX_ECHO : GUARD_CYCLES;
  localparam int MAX_CNT = (MAX_TW > MAX_EG) ? MAX_TW : MAX_EG;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int BW      = $clog2(N_SPOTS);
  localparam int DW      = $clog2(CONFIRM + 1);
  localparam int FW      = $clog2(N_SPOTS + 1);

  localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST    = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] ECHO_LAST    = CW'(MAX_ECHO - 1);
  localparam logic [CW-1:0] GUARD_LAST   = CW'(GUARD_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BAY     = BW'(N_SPOTS - 1);
  localparam logic [DW-1:0] CONFIRM_LAST = DW'(CONFIRM - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, GUARD} state_t;
  typedef enum logic [1:0] {RD_NEAR, RD_FAR, RD_FAULT} reading_t;

  state_t        state, state_next;
  reading_t      reading, reading_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [BW-1:0] bay, bay_next;
  logic          scan_done_next;
  logic          echo_sel, echo_prev;
  logic          apply_reading, agree;
  logic [DW-1:0] confirm_cnt [N_SPOTS];
  logic [FW-1:0] occ_ones;

  assign echo_sel      = echo[bay];
  assign apply_reading = (state == GUARD) && (cnt == '0);
  assign agree         = ((reading == RD_NEAR) && !occupied[bay]) ||
                         ((reading == RD_FAR)  &&  occupied[bay]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      reading   <= RD_NEAR;
      cnt       <= '0;
      bay       <= '0;
      scan_done <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      state     <= state_next;
      reading   <= reading_next;
      cnt       <= cnt_next;
      bay       <= bay_next;
      scan_done <= scan_done_next;
      echo_prev <= echo_sel;
    end
  end

  // Only a 0->1 transition seen while in WAIT starts a measurement, so an echo
  // line already high from before the trigger is never mistaken for a return.
  always_comb begin
    state_next     = state;
    reading_next   = reading;
    cnt_next       = cnt;
    bay_next       = bay;
    scan_done_next = 1'b0;
    trig           = '0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = TRIG;
          cnt_next   = '0;
        end
      end
      TRIG: begin
        trig[bay] = 1'b1;
        if (cnt == TRIG_LAST) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      WAIT: begin
        if (echo_sel && !echo_prev) begin
          state_next = MEAS;
          cnt_next   = '0;
        end else if (cnt == WAIT_LAST) begin
          state_next   = GUARD;
          reading_next = RD_FAULT;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      MEAS: begin
        if (!echo_sel) begin
          state_next   = GUARD;
          reading_next = RD_NEAR;
          cnt_next     = '0;
        end else if (cnt == ECHO_LAST) begin
          state_next   = GUARD;
          reading_next = RD_FAR;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          if (bay == LAST_BAY) begin
            bay_next       = '0;
            scan_done_next = 1'b1;
          end else begin
            bay_next = bay + BW'(1);
          end
          state_next = enable ? TRIG : IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    occ_ones = '0;
    for (int i = 0; i < N_SPOTS; i++) occ_ones = occ_ones + FW'(occupied[i]);
  end

  // A fault leaves the debounce count and occupancy untouched; only agreeing
  // near/far readings advance toward a flip.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied   <= '0;
      fault      <= '0;
      free_count <= FW'(N_SPOTS);
      for (int i = 0; i < N_SPOTS; i++) confirm_cnt[i] <= '0;
    end else begin
      if (apply_reading) begin
        if (reading == RD_FAULT) begin
          fault[bay] <= 1'b1;
        end else begin
          fault[bay] <= 1'b0;
          if (agree) begin
            if (confirm_cnt[bay] == CONFIRM_LAST) begin
              occupied[bay]    <= ~occupied[bay];
              confirm_cnt[bay] <= '0;
            end else begin
              confirm_cnt[bay] <= confirm_cnt[bay] + DW'(1);
            end
          end else begin
            confirm_cnt[bay] <= '0;
          end
        end
      end
      free_count <= FW'(N_SPOTS) - occ_ones;
    end
  end

endmodule

// File: tb/tb_parking_sensor_scheduler.sv
// Bench for parking_sensor_scheduler: a sensor model answers each trigger and
// queues the expected occupancy/fault, compared when the next bay is triggered.
module tb_parking_sensor_scheduler;

  localparam int N          = 4;
  localparam int TRIG       = 10;
  localparam int WAITC      = 200;
  localparam int MAXE       = 100;
  localparam int GUARD      = 30;
  localparam int CONF       = 3;
  localparam int ECHO_DELAY = 5;
  localparam int NEAR_LEN   = 40;
  localparam int FAR_LEN    = 115;
  localparam int M_NEAR     = 0;
  localparam int M_FAR      = 1;
  localparam int M_NONE     = 2;
  localparam int SCAN_BUDGET = 2000;

  typedef struct {
    logic [N-1:0] occ;
    logic [N-1:0] flt;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [N-1:0] echo;
  logic [N-1:0] trig;
  logic [N-1:0] occupied;
  logic [2:0]   free_count;
  logic [N-1:0] fault;
  logic         scan_done;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   scan_cnt  = 0;
  int   exp_bay   = 0;
  int   mode [N];
  exp_t exp_q [$];

  parking_sensor_scheduler #(
    .N_SPOTS(N), .TRIG_CYCLES(TRIG), .WAIT_CYCLES(WAITC),
    .MAX_ECHO(MAXE), .GUARD_CYCLES(GUARD), .CONFIRM(CONF)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .occupied(occupied), .free_count(free_count), .fault(fault), .scan_done(scan_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sensor model plus scoreboard: pushes the expected debounce outcome when a
  // trigger ends, pops and compares it when the following trigger starts.
  initial begin : sensor_monitor
    logic [N-1:0] prev_trig;
    logic         prev_sd;
    logic [N-1:0] m_occ;
    logic [N-1:0] m_flt;
    int           m_cnt [N];
    int           width, sel, echo_bay, phase, phase_cnt, cur_mode, len;
    exp_t         e;
    echo = '0;
    prev_trig = '0; prev_sd = 1'b0; m_occ = '0; m_flt = '0;
    width = 0; sel = 0; echo_bay = 0; phase = 0; phase_cnt = 0; cur_mode = 0; len = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_occ = '0; m_flt = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        exp_q.delete();
        exp_bay = 0; phase = 0; echo = '0;
      end else begin
        if (trig != '0 && prev_trig == '0) begin
          total_cnt++;
          if (!$onehot(trig) || trig != (4'b0001 << exp_bay))
            $display("[TB] FAIL trig_order: got %b, required one-hot for bay %0d", trig, exp_bay);
          else pass_cnt++;
          exp_bay = (exp_bay + 1) % N;
          for (int i = 0; i < N; i++) if (trig[i]) sel = i;
          width = 0;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total_cnt++;
            if (occupied !== e.occ)
              $display("[TB] FAIL sb_occupied: got %b, required %b", occupied, e.occ);
            else pass_cnt++;
            total_cnt++;
            if (fault !== e.flt)
              $display("[TB] FAIL sb_fault: got %b, required %b", fault, e.flt);
            else pass_cnt++;
            total_cnt++;
            if (free_count !== 3'(N - $countones(e.occ)))
              $display("[TB] FAIL sb_free_count: got %0d, required %0d", free_count, N - $countones(e.occ));
            else pass_cnt++;
          end
        end
        if (trig != '0) width++;
        if (trig == '0 && prev_trig != '0) begin
          total_cnt++;
          if (width != TRIG)
            $display("[TB] FAIL trig_width: got %0d cycles, required %0d", width, TRIG);
          else pass_cnt++;
          cur_mode = mode[sel];
          if (cur_mode == M_NONE) begin
            m_flt[sel] = 1'b1;
          end else begin
            m_flt[sel] = 1'b0;
            if ((cur_mode == M_FAR) == m_occ[sel]) begin
              m_cnt[sel]++;
              if (m_cnt[sel] == CONF) begin
                m_occ[sel] = ~m_occ[sel];
                m_cnt[sel] = 0;
              end
            end else begin
              m_cnt[sel] = 0;
            end
          end
          e.occ = m_occ; e.flt = m_flt;
          exp_q.push_back(e);
          echo = '0;
          echo_bay = sel;
          len = (cur_mode == M_FAR) ? FAR_LEN : NEAR_LEN;
          phase = (cur_mode == M_NONE) ? 0 : 2;
          phase_cnt = 0;
        end else if (phase == 2) begin
          phase_cnt++;
          if (phase_cnt == ECHO_DELAY) begin
            echo[echo_bay] = 1'b1;
            phase = 3; phase_cnt = 0;
          end
        end else if (phase == 3) begin
          phase_cnt++;
          if (phase_cnt == len) begin
            echo[echo_bay] = 1'b0;
            phase = 0;
          end
        end
        if (scan_done) begin
          scan_cnt++;
          total_cnt++;
          if (prev_sd) $display("[TB] FAIL scan_done_width: got 2+ cycle pulse, required 1");
          else pass_cnt++;
        end
      end
      prev_trig = trig;
      prev_sd   = scan_done;
    end
  end

  task automatic wait_scan(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (scan_done) ok = 1'b1;
    end
  endtask

  task automatic wait_trig(input logic [N-1:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((want == '0) ? (trig != '0) : (trig == want)) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if (trig !== '0) $display("[TB] FAIL reset_trig: got %b, required 0000", trig); else pass_cnt++;
    total_cnt++; if (occupied !== '0) $display("[TB] FAIL reset_occupied: got %b, required 0000", occupied); else pass_cnt++;
    total_cnt++; if (fault !== '0) $display("[TB] FAIL reset_fault: got %b, required 0000", fault); else pass_cnt++;
    total_cnt++; if (free_count !== 3'd4) $display("[TB] FAIL reset_free_count: got %0d, required 4", free_count); else pass_cnt++;
    total_cnt++; if (scan_done !== 1'b0) $display("[TB] FAIL reset_scan_done: got %b, required 0", scan_done); else pass_cnt++;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++; if (trig !== '0) $display("[TB] FAIL idle_trig: got %b, required 0000 while disabled", trig); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    bit ok;
    int scans0;
    scans0 = scan_cnt;
    for (int i = 0; i < N; i++) mode[i] = M_NEAR;
    enable = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      wait_scan(SCAN_BUDGET, ok);
      total_cnt++;
      if (!ok) $display("[TB] FAIL rr_scan_timeout: got no scan_done in scan %0d, required within %0d cycles", s, SCAN_BUDGET);
      else pass_cnt++;
      if (s == 2) begin
        total_cnt++; if (occupied !== 4'b0000) $display("[TB] FAIL rr_occ_scan2: got %b, required 0000", occupied); else pass_cnt++;
        total_cnt++; if (free_count !== 3'd4) $display("[TB] FAIL rr_free_scan2: got %0d, required 4", free_count); else pass_cnt++;
      end
      if (s == 3) begin
        total_cnt++; if (occupied !== 4'b1111) $display("[TB] FAIL rr_occ_scan3: got %b, required 1111", occupied); else pass_cnt++;
        total_cnt++; if (free_count !== 3'd0) $display("[TB] FAIL rr_free_scan3: got %0d, required 0", free_count); else pass_cnt++;
      end
    end
    @(negedge clk);
    total_cnt++;
    if (scan_cnt - scans0 != 3) $display("[TB] FAIL rr_scan_count: got %0d, required 3", scan_cnt - scans0);
    else pass_cnt++;
  endtask

  task automatic test_far();
    bit ok;
    mode[2] = M_FAR;
    for (int s = 1; s <= 3; s++) begin
      wait_scan(SCAN_BUDGET, ok);
      total_cnt++;
      if (!ok) $display("[TB] FAIL far_scan_timeout: got no scan_done in scan %0d", s);
      else pass_cnt++;
      if (s == 2) begin
        total_cnt++; if (occupied[2] !== 1'b1) $display("[TB] FAIL far_occ2_after2: got %b, required 1", occupied[2]); else pass_cnt++;
      end
      if (s == 3) begin
        total_cnt++; if (occupied !== 4'b1011) $display("[TB] FAIL far_occ_after3: got %b, required 1011", occupied); else pass_cnt++;
        total_cnt++; if (fault[2] !== 1'b0) $display("[TB] FAIL far_fault2: got %b, required 0", fault[2]); else pass_cnt++;
        total_cnt++; if (free_count !== 3'd1) $display("[TB] FAIL far_free: got %0d, required 1", free_count); else pass_cnt++;
      end
    end
  endtask

  task automatic test_no_echo();
    bit ok;
    mode[2] = M_NEAR;
    mode[1] = M_NONE;
    wait_scan(SCAN_BUDGET, ok);
    total_cnt++; if (!ok) $display("[TB] FAIL noecho_timeout: got no scan_done"); else pass_cnt++;
    total_cnt++; if (fault[1] !== 1'b1) $display("[TB] FAIL noecho_fault1: got %b, required 1", fault[1]); else pass_cnt++;
    total_cnt++; if (occupied[1] !== 1'b1) $display("[TB] FAIL noecho_occ1_held: got %b, required 1", occupied[1]); else pass_cnt++;
    mode[1] = M_NEAR;
    wait_scan(SCAN_BUDGET, ok);
    total_cnt++; if (!ok) $display("[TB] FAIL noecho_recover_timeout: got no scan_done"); else pass_cnt++;
    total_cnt++; if (fault[1] !== 1'b0) $display("[TB] FAIL noecho_fault1_clear: got %b, required 0", fault[1]); else pass_cnt++;
  endtask

  task automatic test_debounce();
    bit ok;
    int pattern [6];
    pattern = '{M_NEAR, M_NEAR, M_FAR, M_NEAR, M_NEAR, M_NEAR};
    enable = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    total_cnt++; if (occupied !== '0) $display("[TB] FAIL deb_reset_occ: got %b, required 0000", occupied); else pass_cnt++;
    for (int i = 0; i < N; i++) mode[i] = M_NEAR;
    mode[0] = pattern[0];
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_scan(SCAN_BUDGET, ok);
      total_cnt++;
      if (!ok) $display("[TB] FAIL deb_scan_timeout: got no scan_done for reading %0d", k + 1);
      else pass_cnt++;
      total_cnt++;
      if (occupied[0] !== (k == 5))
        $display("[TB] FAIL deb_occ0_reading%0d: got %b, required %b", k + 1, occupied[0], (k == 5));
      else pass_cnt++;
      if (k < 5) mode[0] = pattern[k + 1];
    end
  endtask

  task automatic test_enable_stop();
    bit ok;
    int seen;
    exp_t e;
    wait_trig(4'b0010, SCAN_BUDGET, ok);
    total_cnt++; if (!ok) $display("[TB] FAIL stop_trig1_timeout: got no trig[1]"); else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (echo[1]) ok = 1'b1;
    end
    @(negedge clk);
    enable = 1'b0;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (trig != '0) seen++;
    end
    total_cnt++; if (seen != 0) $display("[TB] FAIL stop_idle_trig: got %0d trig cycles, required 0", seen); else pass_cnt++;
    total_cnt++;
    if (exp_q.size() != 1) $display("[TB] FAIL stop_pending: got %0d pending readings, required 1", exp_q.size());
    else pass_cnt++;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      total_cnt++; if (occupied !== e.occ) $display("[TB] FAIL stop_occupied: got %b, required %b", occupied, e.occ); else pass_cnt++;
      total_cnt++; if (fault !== e.flt) $display("[TB] FAIL stop_fault: got %b, required %b", fault, e.flt); else pass_cnt++;
    end
    enable = 1'b1;
    wait_trig('0, SCAN_BUDGET, ok);
    total_cnt++;
    if (trig !== 4'b0100) $display("[TB] FAIL resume_bay: got %b, required 0100", trig);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_trig();
    bit ok;
    wait_trig(4'b1000, SCAN_BUDGET, ok);
    total_cnt++; if (!ok) $display("[TB] FAIL midrst_trig3_timeout: got no trig[3]"); else pass_cnt++;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (trig !== '0) $display("[TB] FAIL midrst_trig_async: got %b, required 0000", trig); else pass_cnt++;
    total_cnt++; if (occupied !== '0) $display("[TB] FAIL midrst_occupied: got %b, required 0000", occupied); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_trig('0, 50, ok);
    total_cnt++;
    if (trig !== 4'b0001) $display("[TB] FAIL midrst_restart_bay: got %b, required 0001", trig);
    else pass_cnt++;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < N; i++) mode[i] = M_NEAR;
    test_reset();
    test_round_robin();
    test_far();
    test_no_echo();
    test_debounce();
    test_enable_stop();
    test_reset_mid_trig();
    enable = 1'b0;
    repeat (400) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
